// File: rtl/aib_mac_tx_pkg.sv
// Shared types and sizing helpers for the AIB MAC transmit link controller.
package aib_mac_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_CONF = 3'd1,
        ST_LOCK_REQ  = 3'd2,
        ST_ALIGN     = 3'd3,
        ST_DATA      = 3'd4
    } tx_state_e;

    // Default half-word width and the marker position that goes with it.
    localparam int DWIDTH_DEF = 40;
    localparam int MARK_BIT   = 2 * DWIDTH_DEF - 1;

    // Marker sits in the top bit of the full 2*DWIDTH word.
    function automatic int mark_bit(input int dwidth);
        return 2 * dwidth - 1;
    endfunction

    // Bits needed to hold the values 0..max_val (at least one bit).
    function automatic int cnt_w(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/aib_mac_tx_framer.sv
// Word framer: marker cadence counter plus the registered data_in word.
// While framing, every word carries the marker bit on the cadence and either
// the accepted payload or zeros; outside framing the word is all zero.
module aib_mac_tx_framer
    import aib_mac_tx_pkg::*;
#(
    parameter int DWIDTH      = 40,
    parameter int MARK_PERIOD = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                frame_en,
    input  logic                accept_i,
    input  logic [2*DWIDTH-2:0] user_data_i,
    output logic [2*DWIDTH-1:0] data_o
);

    localparam int MB = mark_bit(DWIDTH);
    localparam int MW = cnt_w(MARK_PERIOD - 1);
    localparam logic [MW-1:0] MLAST = MW'(MARK_PERIOD - 1);

    logic [MW-1:0]       mcnt_q, mcnt_d;
    logic [2*DWIDTH-1:0] data_q, data_d;
    logic                marker;

    assign marker = (mcnt_q == '0);

    // Cadence free-runs while framing and parks at 0 otherwise, so the first
    // ALIGN word always carries a marker and ALIGN->DATA keeps the phase.
    always_comb begin
        mcnt_d = '0;
        if (frame_en) begin
            mcnt_d = (mcnt_q == MLAST) ? '0 : mcnt_q + 1'b1;
        end
    end

    // Word mux: marker + payload when a word is accepted, marker + zeros otherwise.
    always_comb begin
        data_d = '0;
        if (frame_en) begin
            data_d[MB] = marker;
            if (accept_i) begin
                data_d[MB-1:0] = user_data_i;
            end
        end
    end

    // Cadence counter and output word register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mcnt_q <= '0;
            data_q <= '0;
        end else begin
            mcnt_q <= mcnt_d;
            data_q <= data_d;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/aib_mac_tx_link.sv
// MAC-side transmit link controller for one AIB channel. Sequences near-side
// bring-up, requests DCC/DLL lock, streams alignment words until the far-end
// receiver is locked, then frames user payload onto data_in.
module aib_mac_tx_link
    import aib_mac_tx_pkg::*;
#(
    parameter int DWIDTH      = 40,
    parameter int MARK_PERIOD = 4,
    parameter int ALIGN_MIN   = 16,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                m_wr_clk,
    input  logic                m_wr_rst,
    input  logic                i_conf_done,
    input  logic                ns_adapter_rstn,
    input  logic                ms_tx_transfer_en,
    input  logic                fs_mac_rdy,
    input  logic                fs_rx_align_done,
    input  logic [2*DWIDTH-2:0] user_data,
    input  logic                user_valid,
    output logic                user_ready,
    output logic [2*DWIDTH-1:0] data_in,
    output logic                ms_tx_dcc_dll_lock_req,
    output logic                ns_mac_rdy,
    output logic                link_up,
    output logic                err_timeout
);

    localparam int AW = cnt_w(ALIGN_MIN);
    localparam int TW = cnt_w(TIMEOUT_CYC);
    localparam logic [AW-1:0] ALIGN_LAST = AW'(ALIGN_MIN);
    localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYC);

    tx_state_e     state_q, state_d;
    logic [AW-1:0] align_cnt_q, align_cnt_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          err_q, err_d;
    logic          link_ok;
    logic          frame_en;
    logic          accept;
    logic          waiting_d;

    assign link_ok = i_conf_done & ns_adapter_rstn;

    // State register.
    always_ff @(posedge m_wr_clk or posedge m_wr_rst) begin
        if (m_wr_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a lost link or TX path always wins over a forward move.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: state_d = ST_WAIT_CONF;
            ST_WAIT_CONF: begin
                if (link_ok) state_d = ST_LOCK_REQ;
            end
            ST_LOCK_REQ: begin
                if (!link_ok)               state_d = ST_WAIT_CONF;
                else if (ms_tx_transfer_en) state_d = ST_ALIGN;
            end
            ST_ALIGN: begin
                if (!link_ok || !ms_tx_transfer_en) begin
                    state_d = ST_WAIT_CONF;
                end else if (fs_mac_rdy && fs_rx_align_done &&
                             (align_cnt_q == ALIGN_LAST)) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (!link_ok || !ms_tx_transfer_en) state_d = ST_WAIT_CONF;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Moore outputs decoded straight from the state register.
    always_comb begin
        ms_tx_dcc_dll_lock_req = 1'b0;
        ns_mac_rdy             = 1'b0;
        user_ready             = 1'b0;
        link_up                = 1'b0;
        frame_en               = 1'b0;
        case (state_q)
            ST_LOCK_REQ: begin
                ms_tx_dcc_dll_lock_req = 1'b1;
            end
            ST_ALIGN: begin
                ms_tx_dcc_dll_lock_req = 1'b1;
                ns_mac_rdy             = 1'b1;
                frame_en               = 1'b1;
            end
            ST_DATA: begin
                ms_tx_dcc_dll_lock_req = 1'b1;
                ns_mac_rdy             = 1'b1;
                user_ready             = 1'b1;
                link_up                = 1'b1;
                frame_en               = 1'b1;
            end
            default: ;
        endcase
    end

    assign accept = user_ready & user_valid;

    // Alignment word count; the word sent in the entry cycle counts as the
    // first one, so DATA is reachable after exactly ALIGN_MIN ALIGN cycles.
    always_comb begin
        align_cnt_d = align_cnt_q;
        if (state_d == ST_ALIGN && state_q != ST_ALIGN) begin
            align_cnt_d = AW'(1);
        end else if (state_q == ST_ALIGN && align_cnt_q != ALIGN_LAST) begin
            align_cnt_d = align_cnt_q + 1'b1;
        end
    end

    assign waiting_d = (state_d == ST_LOCK_REQ) || (state_d == ST_ALIGN);

    // Wait timer: restarts on every LOCK_REQ/ALIGN entry, saturates, and
    // raises the sticky error; only re-entering WAIT_CONF clears the error.
    always_comb begin
        tmo_cnt_d = '0;
        if (waiting_d && state_d == state_q) begin
            tmo_cnt_d = (tmo_cnt_q == TMO_LAST) ? tmo_cnt_q : tmo_cnt_q + 1'b1;
        end
        err_d = err_q;
        if (state_d == ST_WAIT_CONF && state_q != ST_WAIT_CONF) begin
            err_d = 1'b0;
        end else if (tmo_cnt_d == TMO_LAST) begin
            err_d = 1'b1;
        end
    end

    // Counter and error flag registers.
    always_ff @(posedge m_wr_clk or posedge m_wr_rst) begin
        if (m_wr_rst) begin
            align_cnt_q <= '0;
            tmo_cnt_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            align_cnt_q <= align_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            err_q       <= err_d;
        end
    end

    assign err_timeout = err_q;

    aib_mac_tx_framer #(
        .DWIDTH      (DWIDTH),
        .MARK_PERIOD (MARK_PERIOD)
    ) u_framer (
        .clk_i       (m_wr_clk),
        .rst_i       (m_wr_rst),
        .frame_en    (frame_en),
        .accept_i    (accept),
        .user_data_i (user_data),
        .data_o      (data_in)
    );

endmodule
